// File: rtl/ex_stage.sv
// ex_stage: execute pipeline stage with one-hot ALU and data SRAM request; EX_FORWARD_EN widens EX_wr_bus with bypass data
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         IDreg_valid,
  input  logic         ID_ready_go,
  input  logic [151:0] IDreg_bus,
  input  logic         MEM_allow_in,
  output logic         EX_allow_in,
  output logic         EXreg_valid,
  output logic [70:0]  EXreg_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
`ifdef EX_FORWARD_EN
  output logic [37:0]  EX_wr_bus
`else
  output logic [5:0]   EX_wr_bus
`endif
);
  logic         ex_valid;
  logic [151:0] ex_bus;
  logic [11:0]  alu_op;
  logic [31:0]  src1, src2, rkd_value, pc, alu_result, sra_result;
  logic         mem_en, rf_we, res_from_mem, accept, mem_go;
  logic [3:0]   mem_we;
  logic [4:0]   rf_waddr;
  assign {alu_op, src1, src2, rkd_value, mem_en, mem_we, rf_we, res_from_mem, rf_waddr, pc} = ex_bus;
  assign EX_allow_in = ~ex_valid | MEM_allow_in;
  assign accept      = IDreg_valid & ID_ready_go & EX_allow_in;
  assign mem_go      = ex_valid & MEM_allow_in;
  // occupancy: refill (or bubble) whenever the slot is free or draining
  always_ff @(posedge clk)
    if (reset) ex_valid <= 1'b0;
    else if (EX_allow_in) ex_valid <= IDreg_valid & ID_ready_go;
  // payload register only moves on an actual handoff so stalls keep outputs stable
  always_ff @(posedge clk)
    if (accept) ex_bus <= IDreg_bus;
  assign sra_result = $unsigned($signed(src1) >>> src2[4:0]);
  // one-hot select; an all-zero opcode naturally yields zero
  always_comb
    alu_result = ({32{alu_op[0]}}  & (src1 + src2))
               | ({32{alu_op[1]}}  & (src1 - src2))
               | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
               | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
               | ({32{alu_op[4]}}  & (src1 & src2))
               | ({32{alu_op[5]}}  & ~(src1 | src2))
               | ({32{alu_op[6]}}  & (src1 | src2))
               | ({32{alu_op[7]}}  & (src1 ^ src2))
               | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
               | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
               | ({32{alu_op[10]}} & sra_result)
               | ({32{alu_op[11]}} & src2);
  assign EXreg_valid     = ex_valid;
  assign EXreg_bus       = {res_from_mem, rf_we, rf_waddr, alu_result, pc};
  assign data_sram_en    = mem_en & mem_go;
  assign data_sram_we    = mem_we & {4{mem_go}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;
`ifdef EX_FORWARD_EN
  assign EX_wr_bus = {ex_valid & rf_we & ~res_from_mem, rf_waddr, alu_result};
`else
  assign EX_wr_bus = {ex_valid & rf_we, rf_waddr};
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage with directed corner cases and random traffic
module tb_ex_stage;
`ifdef EX_FORWARD_EN
  localparam int WRW = 38;
`else
  localparam int WRW = 6;
`endif
  logic clk = 0, reset = 1, IDreg_valid = 0, ID_ready_go = 0, MEM_allow_in = 0;
  logic [151:0] IDreg_bus = '0;
  logic EX_allow_in, EXreg_valid, data_sram_en;
  logic [70:0] EXreg_bus;
  logic [3:0] data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [WRW-1:0] EX_wr_bus;
  typedef struct {
    logic [70:0] bus;
    logic en;
    logic [3:0] we;
    logic [31:0] addr, wdata;
    logic [WRW-1:0] wr;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  bit occ = 0, nxt = 0, flush = 0, start = 0;
  ex_stage dut (
    .clk(clk), .reset(reset), .IDreg_valid(IDreg_valid), .ID_ready_go(ID_ready_go),
    .IDreg_bus(IDreg_bus), .MEM_allow_in(MEM_allow_in), .EX_allow_in(EX_allow_in),
    .EXreg_valid(EXreg_valid), .EXreg_bus(EXreg_bus), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .EX_wr_bus(EX_wr_bus)
  );
  always #5 clk = ~clk;
  // reference ALU from the operation list
  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 12; i++)
      if (op[i])
        case (i)
          0: r |= a + b;
          1: r |= a - b;
          2: r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3: r |= (a < b) ? 32'd1 : 32'd0;
          4: r |= a & b;
          5: r |= ~(a | b);
          6: r |= a | b;
          7: r |= a ^ b;
          8: r |= a << b[4:0];
          9: r |= a >> b[4:0];
          10: r |= $unsigned($signed(a) >>> b[4:0]);
          default: r |= b;
        endcase
    return r;
  endfunction
  function automatic logic [151:0] mk(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] rkd, input logic men, input logic [3:0] mwe, input logic rfwe, input logic rfm,
      input logic [4:0] wa, input logic [31:0] pc);
    return {op, a, b, rkd, men, mwe, rfwe, rfm, wa, pc};
  endfunction
  function automatic logic [151:0] rnd_bus();
    int k;
    logic [11:0] op;
    k = $urandom_range(0, 12);
    op = (k == 12) ? 12'd0 : 12'(1 << k);
    return mk(op, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
  endfunction
  function automatic exp_t model(input logic [151:0] b);
    exp_t e;
    logic [31:0] r;
    r = alu_ref(b[151:140], b[139:108], b[107:76]);
    e.bus = {b[37], b[38], b[36:32], r, b[31:0]};
    e.en = b[43];
    e.we = b[42:39];
    e.addr = r;
    e.wdata = b[75:44];
`ifdef EX_FORWARD_EN
    e.wr = {b[38] & ~b[37], b[36:32], r};
`else
    e.wr = {b[38], b[36:32]};
`endif
    return e;
  endfunction
  // one cycle of stimulus; the occupancy model follows the handshake rules directly
  task automatic issue(input bit r, input bit v, input bit g, input bit m, input logic [151:0] b);
    @(posedge clk); #1;
    occ = nxt;
    if (flush) begin sb.delete(); flush = 0; end
    reset = r; IDreg_valid = v; ID_ready_go = g; MEM_allow_in = m; IDreg_bus = b;
    if (r) begin nxt = 0; flush = 1; end
    else if (!occ || m) begin
      nxt = v && g;
      if (v && g) sb.push_back(model(b));
    end
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, a, e); end
  endtask
  // monitor: compares presented outputs with the head of the scoreboard
  always @(negedge clk) if (start) begin
    chk("valid", 32'(EXreg_valid), 32'(occ));
    chk("allow_in", 32'(EX_allow_in), 32'(!occ || MEM_allow_in));
    if (occ) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL sb_empty: got valid=1 expected queued item"); end
      else begin
        if (EXreg_bus !== sb[0].bus) begin errors++; $display("FAIL exbus: got %h expected %h", EXreg_bus, sb[0].bus); end
        checks++;
        if (EX_wr_bus !== sb[0].wr) begin errors++; $display("FAIL wr_bus: got %h expected %h", EX_wr_bus, sb[0].wr); end
        if (MEM_allow_in) begin
          chk("sram_en", 32'(data_sram_en), 32'(sb[0].en));
          chk("sram_we", 32'(data_sram_we), 32'(sb[0].we));
          chk("sram_addr", data_sram_addr, sb[0].addr);
          chk("sram_wdata", data_sram_wdata, sb[0].wdata);
          void'(sb.pop_front());
        end else begin
          chk("stall_en", 32'(data_sram_en), 0);
          chk("stall_we", 32'(data_sram_we), 0);
        end
      end
    end else begin
      chk("idle_en", 32'(data_sram_en), 0);
      chk("idle_we", 32'(data_sram_we), 0);
      chk("idle_wr_valid", 32'(EX_wr_bus[WRW-1]), 0);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [151:0] st, ld;
    issue(1, 0, 0, 0, '0);
    issue(1, 0, 0, 0, '0);
    start = 1;
    issue(0, 0, 0, 0, '0);
    chk("rst_valid", 32'(EXreg_valid), 0);
    chk("rst_allow", 32'(EX_allow_in), 1);
    chk("rst_en", 32'(data_sram_en), 0);
    issue(0, 1, 1, 1, mk(12'h001, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 1, 0, 5'd3, 32'h1C000000));
    issue(0, 0, 0, 1, '0);
    chk("add_valid", 32'(EXreg_valid), 1);
    chk("add_wrap", EXreg_bus[63:32], 32'h0);
    issue(0, 1, 1, 1, mk(12'h004, 32'h80000000, 32'd1, 0, 0, 0, 1, 0, 5'd4, 32'h1C000010));
    issue(0, 1, 1, 1, mk(12'h008, 32'h80000000, 32'd1, 0, 0, 0, 1, 0, 5'd5, 32'h1C000014));
    chk("slt", EXreg_bus[63:32], 32'd1);
    issue(0, 1, 1, 1, mk(12'h400, 32'h80000000, 32'd4, 0, 0, 0, 1, 0, 5'd6, 32'h1C000018));
    chk("sltu", EXreg_bus[63:32], 32'd0);
    issue(0, 0, 0, 1, '0);
    chk("sra", EXreg_bus[63:32], 32'hF8000000);
    st = mk(12'h001, 32'h1000, 32'd8, 32'hDEADBEEF, 1, 4'hF, 0, 0, 5'd0, 32'h1C000020);
    issue(0, 1, 1, 1, st);
    for (int i = 0; i < 3; i++) begin
      issue(0, 1, 1, 0, rnd_bus());
      chk("store_stall_en", 32'(data_sram_en), 0);
    end
    issue(0, 0, 0, 1, '0);
    chk("store_en", 32'(data_sram_en), 1);
    chk("store_we", 32'(data_sram_we), 32'hF);
    chk("store_addr", data_sram_addr, 32'h1008);
    chk("store_wdata", data_sram_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      issue(0, 1, 1, 1, mk(12'h001, i, 1, 0, 0, 0, 1, 0, 5'd7, 32'h1C000000 + 32'(4 * i)));
      if (i > 0) chk("b2b_pc", EXreg_bus[31:0], 32'h1C000000 + 32'(4 * (i - 1)));
    end
    issue(0, 0, 0, 1, '0);
    chk("b2b_pc_last", EXreg_bus[31:0], 32'h1C000008);
    chk("b2b_valid", 32'(EXreg_valid), 1);
    issue(0, 1, 1, 1, st);
    issue(0, 0, 0, 0, '0);
    issue(1, 0, 0, 0, '0);
    issue(0, 0, 0, 0, '0);
    chk("rst_stall_valid", 32'(EXreg_valid), 0);
    chk("rst_stall_en", 32'(data_sram_en), 0);
    chk("rst_stall_allow", 32'(EX_allow_in), 1);
    ld = mk(12'h001, 32'h2000, 32'd4, 0, 1, 0, 1, 1, 5'd9, 32'h1C000040);
    issue(0, 1, 1, 1, ld);
    issue(0, 1, 0, 1, rnd_bus());
    chk("ld_valid", 32'(EXreg_valid), 1);
`ifdef EX_FORWARD_EN
    chk("ld_fwd_bit", 32'(EX_wr_bus[37]), 0);
`endif
    issue(0, 0, 0, 1, '0);
    chk("bubble_valid", 32'(EXreg_valid), 0);
    chk("bubble_wr", 32'(EX_wr_bus[WRW-1]), 0);
    for (int i = 0; i < 3000; i++)
      issue($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 7, rnd_bus());
    issue(0, 0, 0, 1, '0);
    issue(0, 0, 0, 1, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
